bn_route_ctrl: RTL and testbench
================================

Name: bn_route_ctrl

Overview:
- Sequencer for the 1-to-3 demultiplexer in the batch-normalization datapath.
- Accepts one activation stream and steps it through three phases, one batch each:
  - MEAN: data goes to demux output 0 (sum accumulator).
  - VAR: data goes to output 1 (variance accumulator).
  - NORM: data goes to output 2 (normalize/scale unit).
- Drives the demux select together with a registered, phase-aligned copy of the data, and reports phase/batch completion to the top-level controller.

Parameters:
- DATA_WIDTH, 16, width of the activation data routed through the demux.
- BATCH_SIZE, 32, elements per phase; legal range 1 to 2**CNT_WIDTH.
- CNT_WIDTH, 6, width of the element counter; must hold BATCH_SIZE-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin one three-phase batch sequence; sampled only in IDLE.
- in_valid  input  1  upstream data valid.
- in_ready  output  1  upstream may transfer; combinational from state and out_stall.
- in_data  input  DATA_WIDTH  upstream activation.
- out_stall  input  1  downstream backpressure; blocks new transfers.
- sel  output  2  demux select: 00 = MEAN, 01 = VAR, 10 = NORM, 11 = park (all demux outputs zero).
- dmux_data  output  DATA_WIDTH  registered data to the demux in0.
- dmux_valid  output  1  dmux_data/sel carry a real element this cycle.
- phase  output  2  current phase: 0 IDLE, 1 MEAN, 2 VAR, 3 NORM.
- phase_done  output  3  one-cycle pulse per phase; bit0 MEAN, bit1 VAR, bit2 NORM.
- busy  output  1  high in MEAN, VAR and NORM.
- done  output  1  one-cycle pulse after the NORM phase completes.

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE, elem_cnt = 0.
  - sel = 2'b11, dmux_data = 0, dmux_valid = 0.
  - phase_done = 0, done = 0, busy = 0.
  - in_ready = 0 while rst_n is low.
- States: IDLE -> MEAN -> VAR -> NORM -> DONE -> IDLE.
  - IDLE: start=1 moves to MEAN next cycle. in_ready = 0.
  - MEAN/VAR/NORM: in_ready = !out_stall. A transfer is in_valid && in_ready.
  - DONE: lasts exactly 1 cycle. done = 1, in_ready = 0. Returns to IDLE.
- On each transfer:
  - Next cycle: dmux_data = in_data, sel = code of the accepting phase, dmux_valid = 1. Latency is 1 cycle.
  - elem_cnt increments.
- On any cycle without a transfer: next cycle dmux_valid = 0 and sel = 2'b11. dmux_data holds its previous value.
- Phase end: a transfer with elem_cnt == BATCH_SIZE-1 does all of the following:
  - Sets elem_cnt to 0.
  - Advances the state (NORM advances to DONE).
  - Pulses the matching phase_done bit in the next cycle, i.e. the same cycle that last element appears on dmux_data.
- Consecutive transfers are allowed every cycle, including across a phase boundary. The first element of the next phase is accepted in the cycle right after the last element of the previous one.
- BATCH_SIZE = 1: every transfer ends its phase.
- start while busy or in DONE is ignored; a sequence is never restarted mid-batch.
- out_stall asserted mid-phase:
  - No acceptance; elem_cnt and state hold.
  - The output register already issued is not retracted.
- in_valid with in_ready = 0: no transfer; upstream must hold its data.
- No reachable state ever drives sel = 2'b11 together with dmux_valid = 1.
- Reset mid-phase discards the partial batch; no phase_done or done pulse is produced.
- phase reflects the current state, registered. busy = (phase != 0).

Optional Feature:
- Macro: BN_ROUTE_INFER_MODE_EN.
- Defined:
  - Adds input port infer_mode (1 bit), sampled with start in IDLE.
  - If infer_mode = 1, the FSM goes IDLE -> NORM directly, skipping MEAN and VAR. Inference uses stored statistics.
  - phase_done[0] and phase_done[1] do not pulse in that sequence.
  - If infer_mode = 0, behaviour is identical to the full sequence.
- Not defined: the port is absent and every sequence runs all three phases.

Test Plan (BATCH_SIZE = 4, DATA_WIDTH = 16):
- Reset, then idle 5 cycles -> sel = 11, dmux_valid = 0, in_ready = 0, busy = 0, done = 0.
- start, then 12 back-to-back values 0x0001..0x000C with in_valid held high ->
  - sel = 00 for 0x0001-0x0004, 01 for 0x0005-0x0008, 10 for 0x0009-0x000C, each 1 cycle after acceptance.
  - phase_done = 001, 010, 100 alongside 0x0004, 0x0008, 0x000C.
  - done pulses once, 1 cycle after the 0x000C output.
- out_stall high for 3 cycles after the 2nd VAR element ->
  - in_ready = 0 and dmux_valid = 0 with sel = 11 during the stall.
  - elem_cnt holds at 2; the remaining 2 VAR elements route with sel = 01 after the stall.
- Assert rst_n = 0 after the 6th element, then restart -> outputs return to reset values immediately; the new batch starts in MEAN with count 0 and no stale pulses.
- start pulsed during NORM -> ignored; exactly one done pulse and one sequence.
- BN_ROUTE_INFER_MODE_EN defined, start with infer_mode = 1, 4 elements -> all routed with sel = 10, only phase_done[2] pulses, then done.

Source files
------------

// File: rtl/bn_route_ctrl.sv
// bn_route_ctrl: phase sequencer for the batch-normalization 1-to-3 demux.
// Steps one activation stream through MEAN, VAR and NORM, one batch each,
// and drives the demux select with a registered, phase-aligned data copy.
// Optional feature: define BN_ROUTE_INFER_MODE_EN to add the infer_mode
// input, which sends a sequence straight to NORM using stored statistics.
module bn_route_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int BATCH_SIZE = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
`ifdef BN_ROUTE_INFER_MODE_EN
    input  logic                  infer_mode,
`endif
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  out_stall,
    output logic [1:0]            sel,
    output logic [DATA_WIDTH-1:0] dmux_data,
    output logic                  dmux_valid,
    output logic [1:0]            phase,
    output logic [2:0]            phase_done,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MEAN,
        S_VAR,
        S_NORM,
        S_DONE
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(BATCH_SIZE - 1);
    localparam logic [1:0]           SEL_PARK = 2'b11;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [CNT_WIDTH-1:0]    r_elem_cnt;
    logic [CNT_WIDTH-1:0]    w_next_cnt;
    logic                    w_active;
    logic                    w_xfer;
    logic                    w_last;
    logic                    w_infer;
    logic [1:0]              w_sel_code;
    logic [2:0]              w_done_bit;

    logic [1:0]              r_sel;
    logic [DATA_WIDTH-1:0]   r_dmux_data;
    logic                    r_dmux_valid;
    logic [1:0]              r_phase;
    logic [2:0]              r_phase_done;
    logic                    r_busy;
    logic                    r_done;

    // Phase number reported to the controller: 0 outside the three data phases.
    function automatic logic [1:0] phase_of(input state_t s);
        case (s)
            S_MEAN:  return 2'd1;
            S_VAR:   return 2'd2;
            S_NORM:  return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

`ifdef BN_ROUTE_INFER_MODE_EN
    assign w_infer = infer_mode;
`else
    assign w_infer = 1'b0;
`endif

    assign w_active = (r_state == S_MEAN) || (r_state == S_VAR) || (r_state == S_NORM);
    // Reset forces r_state to IDLE asynchronously, so in_ready drops with rst_n.
    assign in_ready = w_active && !out_stall;
    assign w_xfer   = in_valid && in_ready;
    assign w_last   = (r_elem_cnt == LAST_IDX);

    // Demux code and phase_done bit belonging to the phase accepting data now.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_sel_code = SEL_PARK;
        w_done_bit = 3'b000;
        case (r_state)
            S_MEAN: begin w_sel_code = 2'b00; w_done_bit = 3'b001; end
            S_VAR:  begin w_sel_code = 2'b01; w_done_bit = 3'b010; end
            S_NORM: begin w_sel_code = 2'b10; w_done_bit = 3'b100; end
            default: ;
        endcase
    end

    // Next-state and element-count logic; a phase ends on its last transfer.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_elem_cnt;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = w_infer ? S_NORM : S_MEAN;
                end
            end
            S_MEAN, S_VAR, S_NORM: begin
                if (w_xfer) begin
                    if (w_last) begin
                        w_next_cnt = '0;
                        case (r_state)
                            S_MEAN:  w_next_state = S_VAR;
                            S_VAR:   w_next_state = S_NORM;
                            default: w_next_state = S_DONE;
                        endcase
                    end else begin
                        w_next_cnt = r_elem_cnt + CNT_WIDTH'(1);
                    end
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // State and element counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_elem_cnt <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state    <= w_next_state;
            r_elem_cnt <= w_next_cnt;
        end
    end

    // Output register: data, select and pulses aligned one cycle after acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel        <= SEL_PARK;
            r_dmux_data  <= '0;
            r_dmux_valid <= 1'b0;
            r_phase      <= 2'd0;
            r_phase_done <= 3'b000;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_sel        <= w_xfer ? w_sel_code : SEL_PARK;
            r_dmux_valid <= w_xfer;
            if (w_xfer) begin
                r_dmux_data <= in_data;
            end
            r_phase_done <= (w_xfer && w_last) ? w_done_bit : 3'b000;
            r_phase      <= phase_of(w_next_state);
            r_busy       <= (phase_of(w_next_state) != 2'd0);
            r_done       <= (r_state == S_DONE);
        end
    end

    assign sel        = r_sel;
    assign dmux_data  = r_dmux_data;
    assign dmux_valid = r_dmux_valid;
    assign phase      = r_phase;
    assign phase_done = r_phase_done;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_bn_route_ctrl.sv
// tb_bn_route_ctrl: scoreboard bench for bn_route_ctrl with BATCH_SIZE = 4.
// A behavioural model in the driver pushes the expected demux word for every
// accepted element; the monitor pops and compares one cycle later.
module tb_bn_route_ctrl;

    localparam int DW    = 16;
    localparam int BATCH = 4;

    typedef struct {
        logic [1:0]    sel;
        logic [DW-1:0] data;
        logic [2:0]    pd;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          infer_mode = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_stall = 1'b0;
    logic [1:0]    sel;
    logic [DW-1:0] dmux_data;
    logic          dmux_valid;
    logic [1:0]    phase;
    logic [2:0]    phase_done;
    logic          busy;
    logic          done;

    int n_vec  = 0;
    int n_miss = 0;
    int n_done = 0;

    // model: 0 idle, 1 mean, 2 var, 3 norm, 4 done
    int            m_st = 0;
    int            m_cnt = 0;
    logic          m_done = 1'b0;
    logic [DW-1:0] m_last = '0;
    exp_t          sb_q[$];

    bn_route_ctrl #(.DATA_WIDTH(DW), .BATCH_SIZE(BATCH), .CNT_WIDTH(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
`ifdef BN_ROUTE_INFER_MODE_EN
        .infer_mode (infer_mode),
`endif
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_stall  (out_stall),
        .sel        (sel),
        .dmux_data  (dmux_data),
        .dmux_valid (dmux_valid),
        .phase      (phase),
        .phase_done (phase_done),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // One cycle of stimulus; model advances to the state the DUT holds after the edge.
    task automatic step(input logic st, input logic v, input logic [DW-1:0] d, input logic stall);
        logic exp_rdy;
        logic xfer;
        exp_t e;
        @(negedge clk);
        start     = st;
        in_valid  = v;
        in_data   = d;
        out_stall = stall;
        #1;
        exp_rdy = (m_st >= 1) && (m_st <= 3) && !stall;
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        xfer   = exp_rdy && v;
        m_done = (m_st == 4);
        if (xfer) begin
            e.sel  = 2'(m_st - 1);
            e.data = d;
            e.pd   = (m_cnt == BATCH - 1) ? 3'(1 << (m_st - 1)) : 3'b000;
            sb_q.push_back(e);
        end
        case (m_st)
            0: if (st) m_st = infer_mode ? 3 : 1;
            1, 2, 3: if (xfer) begin
                if (m_cnt == BATCH - 1) begin
                    m_cnt = 0;
                    m_st  = m_st + 1;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
            default: m_st = 0;
        endcase
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic feed(input logic [DW-1:0] first, input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, first + DW'(i), 1'b0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        m_st     = 0;
        m_cnt    = 0;
        m_done   = 1'b0;
        m_last   = '0;
        sb_q.delete();
        #1;
        check("rst_sel", 32'(sel), 32'h3);
        check("rst_valid", 32'(dmux_valid), 32'h0);
        check("rst_data", 32'(dmux_data), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h0);
        check("rst_pdone", 32'(phase_done), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: compare registered outputs just after each rising edge.
    always @(posedge clk) begin
        exp_t e;
        logic [1:0] exp_phase;
        #1;
        exp_phase = (m_st >= 1 && m_st <= 3) ? 2'(m_st) : 2'd0;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("valid", 32'(dmux_valid), 32'h1);
            check("sel", 32'(sel), 32'(e.sel));
            check("data", 32'(dmux_data), 32'(e.data));
            check("phase_done", 32'(phase_done), 32'(e.pd));
            m_last = e.data;
        end else begin
            check("idle_valid", 32'(dmux_valid), 32'h0);
            check("idle_sel", 32'(sel), 32'h3);
            check("hold_data", 32'(dmux_data), 32'(m_last));
            check("idle_pdone", 32'(phase_done), 32'h0);
        end
        check("phase", 32'(phase), 32'(exp_phase));
        check("busy", 32'(busy), 32'(exp_phase != 2'd0));
        check("done", 32'(done), 32'(m_done));
        if (done) n_done++;
    end

    initial begin
        int exp_n_done;
        exp_n_done = 0;

        // reset and quiet idle
        apply_reset();
        idle(5);

        // full back-to-back sequence 0x0001..0x000C
        step(1'b1, 1'b0, '0, 1'b0);
        feed(16'h0001, 12);
        idle(3);
        exp_n_done++;

        // stall for 3 cycles after the 2nd VAR element
        step(1'b1, 1'b0, '0, 1'b0);
        feed(16'h0101, 6);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'h0107, 1'b1);
        feed(16'h0107, 6);
        idle(3);
        exp_n_done++;

        // reset mid-VAR after the 6th element, then a clean restart
        step(1'b1, 1'b0, '0, 1'b0);
        feed(16'h0201, 6);
        apply_reset();
        idle(2);
        step(1'b1, 1'b0, '0, 1'b0);
        feed(16'h0301, 12);
        idle(3);
        exp_n_done++;

        // start pulsed during NORM is ignored
        step(1'b1, 1'b0, '0, 1'b0);
        feed(16'h0401, 9);
        step(1'b1, 1'b1, 16'h040A, 1'b0);
        feed(16'h040B, 2);
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        idle(3);
        exp_n_done++;

        // random valid/stall through a full sequence
        step(1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 300 && m_st != 0; i++)
            step(1'b0, 1'($urandom_range(0, 1)), DW'($urandom), ($urandom_range(0, 3) == 0));
        check("rand_seq_ended", 32'(m_st), 32'h0);
        idle(3);
        exp_n_done++;

`ifdef BN_ROUTE_INFER_MODE_EN
        // inference: straight to NORM
        infer_mode = 1'b1;
        step(1'b1, 1'b0, '0, 1'b0);
        infer_mode = 1'b0;
        feed(16'h0501, 4);
        idle(3);
        exp_n_done++;
`endif

        check("done_count", 32'(n_done), 32'(exp_n_done));
        check("sb_empty", 32'(sb_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
